// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and buffered LSU load data into one
// registered regfile write, with starvation protection and decode hazard info.
module wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [XLEN-1:0]          alu_result,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_W-1:0]        lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  input  logic [ADDR_W-1:0]        chk_rs1,
  input  logic [ADDR_W-1:0]        chk_rs2,
  output logic                     hazard,
  output logic [ADDR_W-1:0]        rd,
  output logic [XLEN-1:0]          result,
  output logic                     reg_write,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
  logic [XLEN-1:0]   fifo_data_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [SW-1:0]     starve_q;

  logic starve, pop, sel_alu, push;

  always_comb begin
    starve    = (starve_q == SW'(STARVE_MAX));
    pop       = 1'b0;
    sel_alu   = 1'b0;
    alu_ready = 1'b0;
    if (!reset) begin
      // A starved head blocks the ALU for one cycle; otherwise the ALU has priority.
      if (starve && (count_q != '0)) begin
        pop = 1'b1;
      end else begin
        alu_ready = 1'b1;
        if (alu_valid) begin
          sel_alu = 1'b1;
        end else if (count_q != '0) begin
          pop = 1'b1;
        end
      end
    end
    lsu_ready = !reset && (count_q < CW'(DEPTH));
    push      = lsu_valid && lsu_ready && (lsu_rd != '0);
  end

  always_comb begin : p_hazard
    logic [PW-1:0] idx;
    hazard = 1'b0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) &&
          (((chk_rs1 != '0) && (fifo_rd_q[idx] == chk_rs1)) ||
           ((chk_rs2 != '0) && (fifo_rd_q[idx] == chk_rs2)))) begin
        hazard = 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read below count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= lsu_rd;
      fifo_data_q[wr_ptr_q] <= lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rd        <= '0;
      result    <= '0;
      reg_write <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);

      if (pop || (count_q == '0)) begin
        starve_q <= '0;
      end else if (!starve) begin
        starve_q <= starve_q + 1'b1;
      end

      if (sel_alu) begin
        rd        <= alu_rd;
        result    <= alu_result;
        reg_write <= (alu_rd != '0);
      end else if (pop) begin
        rd        <= fifo_rd_q[rd_ptr_q];
        result    <= fifo_data_q[rd_ptr_q];
        reg_write <= (fifo_rd_q[rd_ptr_q] != '0);
      end else begin
        reg_write <= 1'b0;
      end
    end
  end

  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_arbiter;

  localparam int XLEN       = 32;
  localparam int ADDR_W     = 4;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic              clk, reset;
  logic              alu_valid, alu_ready, lsu_valid, lsu_ready, hazard, reg_write;
  logic [ADDR_W-1:0] alu_rd, lsu_rd, chk_rs1, chk_rs2, rd;
  logic [XLEN-1:0]   alu_result, lsu_data, result;
  logic [1:0]        fifo_count;

  wb_arbiter #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
    .rd(rd), .result(result), .reg_write(reg_write), .fifo_count(fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } ent_t;

  ent_t              q[$];
  int                sc;
  logic [ADDR_W-1:0] m_rd;
  logic [XLEN-1:0]   m_res;
  logic              m_we;
  int                checks, errors;
  logic [ADDR_W-1:0] wlog[$];
  logic              last_alu_acc, last_lsu_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with inputs set: compares DUT against the model,
  // advances the model across the next posedge, logs writes, returns at negedge.
  task automatic step();
    bit   e_lr, e_ar, e_hz, starve, pop_sel;
    int   pre;
    ent_t h;
    #1;
    e_lr   = !reset && (q.size() < DEPTH);
    starve = (sc == STARVE_MAX);
    e_ar   = !reset && !(starve && q.size() > 0);
    e_hz   = 1'b0;
    foreach (q[i]) begin
      if ((chk_rs1 != 0 && q[i].rd == chk_rs1) || (chk_rs2 != 0 && q[i].rd == chk_rs2))
        e_hz = 1'b1;
    end
    chk("fifo_count", fifo_count, q.size());
    chk("lsu_ready", lsu_ready, e_lr);
    chk("alu_ready", alu_ready, e_ar);
    chk("reg_write", reg_write, m_we);
    if (m_we) begin
      chk("rd", rd, m_rd);
      chk("result", result, m_res);
    end
    if (!reset) chk("hazard", hazard, e_hz);
    last_alu_acc = alu_valid && e_ar;
    last_lsu_acc = lsu_valid && e_lr;

    if (reset) begin
      q.delete();
      sc    = 0;
      m_rd  = '0;
      m_res = '0;
      m_we  = 1'b0;
    end else begin
      pre     = q.size();
      pop_sel = (pre > 0) && (starve || !alu_valid);
      if (pop_sel) begin
        h     = q.pop_front();
        m_rd  = h.rd;
        m_res = h.data;
        m_we  = 1'b1;
      end else if (alu_valid) begin
        m_rd  = alu_rd;
        m_res = alu_result;
        m_we  = (alu_rd != 0);
      end else begin
        m_we = 1'b0;
      end
      if (lsu_valid && e_lr && lsu_rd != 0) q.push_back('{rd: lsu_rd, data: lsu_data});
      if (pop_sel || pre == 0) sc = 0;
      else if (sc < STARVE_MAX) sc++;
    end

    @(posedge clk);
    #1;
    if (reg_write === 1'b1) wlog.push_back(rd);
    @(negedge clk);
  endtask

  initial begin
    logic [ADDR_W-1:0] sel[$];
    checks = 0; errors = 0;
    sc = 0; m_rd = '0; m_res = '0; m_we = 1'b0;
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    chk_rs1 = '0; chk_rs2 = '0;
    last_alu_acc = 1'b0; last_lsu_acc = 1'b0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // 1: single ALU write, then idle
    alu_valid = 1'b1; alu_rd = 4'd5; alu_result = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    chk("t1_rd", rd, 5);
    chk("t1_result", result, 32'hDEADBEEF);
    chk("t1_we", reg_write, 1);
    step();
    chk("t1_idle_we", reg_write, 0);

    // 2: lone load, write at T+2, hazard only at T+1
    lsu_valid = 1'b1; lsu_rd = 4'd3; lsu_data = 32'h11; chk_rs1 = 4'd3;
    #1 chk("t2_hazard_T", hazard, 0);
    step();
    lsu_valid = 1'b0;
    #1 chk("t2_hazard_T1", hazard, 1);
    chk("t2_we_T1", reg_write, 0);
    step();
    chk("t2_we_T2", reg_write, 1);
    chk("t2_rd", rd, 3);
    chk("t2_result", result, 32'h11);
    #1 chk("t2_hazard_T2", hazard, 0);
    chk_rs1 = '0;

    // 3: back-pressure with ALU busy
    wlog.delete();
    alu_valid = 1'b1; alu_rd = 4'd7; alu_result = 32'h77;
    lsu_valid = 1'b1; lsu_rd = 4'd8; lsu_data = 32'h80;
    step();
    lsu_rd = 4'd9; lsu_data = 32'h90;
    step();
    lsu_rd = 4'd10; lsu_data = 32'hA0;
    #1 chk("t3_lsu_ready_full", lsu_ready, 0);
    chk("t3_count_full", fifo_count, 2);
    alu_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (last_lsu_acc) lsu_valid = 1'b0;
    end
    foreach (wlog[i]) if (wlog[i] != 4'd7) sel.push_back(wlog[i]);
    chk("t3_nwrites", sel.size(), 3);
    if (sel.size() == 3) begin
      chk("t3_order0", sel[0], 8);
      chk("t3_order1", sel[1], 9);
      chk("t3_order2", sel[2], 10);
    end

    // 4: starvation with ALU constantly valid
    wlog.delete();
    alu_valid = 1'b1; alu_rd = 4'd6; alu_result = 32'h66;
    lsu_valid = 1'b1; lsu_rd = 4'd4; lsu_data = 32'h44;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) #1 chk("t4_alu_ready_starve", alu_ready, 0);
      step();
      if (i == 0) lsu_valid = 1'b0;
    end
    alu_valid = 1'b0;
    chk("t4_nwrites", wlog.size(), 7);
    if (wlog.size() == 7) begin
      chk("t4_alu_before", wlog[4], 6);
      chk("t4_load", wlog[5], 4);
      chk("t4_alu_after", wlog[6], 6);
    end
    step();

    // 5: x0 writes dropped
    wlog.delete();
    alu_valid = 1'b1; alu_rd = '0; alu_result = 32'h1234;
    lsu_valid = 1'b1; lsu_rd = '0; lsu_data = 32'h5678;
    #1 chk("t5_lsu_ready", lsu_ready, 1);
    chk("t5_hazard_x0", hazard, 0);
    for (int i = 0; i < 3; i++) step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk("t5_count", fifo_count, 0);
    chk("t5_nwrites", wlog.size(), 0);

    // 6: reset with a full FIFO discards it
    alu_valid = 1'b1; alu_rd = 4'd6; alu_result = 32'h66;
    lsu_valid = 1'b1; lsu_rd = 4'd11; lsu_data = 32'hB0;
    step();
    lsu_rd = 4'd12; lsu_data = 32'hC0;
    step();
    chk("t6_count_full", fifo_count, 2);
    reset = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
    step();
    reset = 1'b0;
    chk("t6_count_rst", fifo_count, 0);
    chk("t6_we_rst", reg_write, 0);
    wlog.delete();
    for (int i = 0; i < 6; i++) step();
    chk("t6_no_writes", wlog.size(), 0);

    // randomized traffic with valid-hold protocol on both sources
    last_alu_acc = 1'b0; last_lsu_acc = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!alu_valid || last_alu_acc) begin
        alu_valid  = ($urandom_range(0, 99) < 60);
        alu_rd     = ADDR_W'($urandom_range(0, 7));
        alu_result = $urandom;
      end
      if (!lsu_valid || last_lsu_acc) begin
        lsu_valid = ($urandom_range(0, 99) < 50);
        lsu_rd    = ADDR_W'($urandom_range(0, 7));
        lsu_data  = $urandom;
      end
      chk_rs1 = ADDR_W'($urandom_range(0, 7));
      chk_rs2 = ADDR_W'($urandom_range(0, 7));
      reset   = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
